// File: rtl/demosaic_pkg.sv
// demosaic_pkg: shared types and window helper for the 2x2 Bayer converter
package demosaic_pkg;
    typedef enum logic [1:0] {
        PAT_RGGB = 2'd0,
        PAT_GRBG = 2'd1,
        PAT_GBRG = 2'd2,
        PAT_BGGR = 2'd3
    } pattern_e;
    typedef enum logic {
        MODE_DEMOSAIC = 1'b0,
        MODE_BIN      = 1'b1
    } mode_e;
    // Window index of the sample at column offset px, row offset py from P00
    function automatic logic [1:0] win_pos(input logic px, input logic py);
        return {py, px};
    endfunction
endpackage

// File: rtl/line_buf_1p.sv
// line_buf_1p: single-port line RAM, read returns the data held before the same-cycle write
module line_buf_1p #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
endmodule

// File: rtl/bayer_demosaic_2x2.sv
// bayer_demosaic_2x2: raw Bayer stream to RGB from a 2x2 window, full rate or 2x2 binned
module bayer_demosaic_2x2
    import demosaic_pkg::*;
#(
    parameter int DATA_W   = 10,
    parameter int OUT_W    = 8,
    parameter int LINE_MAX = 1024,
    parameter int X_W      = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_fval,
    input  logic              i_lval,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_pattern,
    input  logic              i_mode,
    output logic [OUT_W-1:0]  o_r,
    output logic [OUT_W-1:0]  o_g,
    output logic [OUT_W-1:0]  o_b,
    output logic              o_valid,
    output logic              o_sof,
    output logic              o_sol,
    output logic              o_ovf
);
    localparam int A_W = $clog2(LINE_MAX);
    localparam logic [X_W-1:0] X_SAT = '1;
    localparam logic [X_W-1:0] X_LIM = X_W'(LINE_MAX);
    logic fval_q, lval_q, armed, sof_pend;
    pattern_e pat;
    mode_e mode;
    logic [X_W-1:0] x, y, x_cur, y_cur, s1_x, s1_y, last_y;
    logic [DATA_W-1:0] ram_q, prev_d, cur_d, s1_cur;
    logic s1_valid, frame_start, line_start, line_end, accept, in_range, wr;
    logic cx, cy, emit;
    logic [DATA_W-1:0] win [4];
    logic [DATA_W-1:0] r_raw, b_raw;
    logic [DATA_W:0] g_sum;
    assign frame_start = i_fval & ~fval_q;
    assign line_start  = i_lval & ~lval_q;
    assign line_end    = ~i_lval & lval_q;
    assign accept      = i_fval & i_lval & i_valid;
    assign x_cur       = line_start ? '0 : x;
    assign y_cur       = frame_start ? '0 : y;
    assign in_range    = x_cur < X_LIM;
    assign wr          = accept & in_range;
    // fval_q resets high so a frame already running at reset release is not mistaken for a new one
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            fval_q <= 1'b1;
            lval_q <= 1'b0;
            x      <= '0;
            y      <= '0;
            armed  <= 1'b0;
            pat    <= PAT_RGGB;
            mode   <= MODE_DEMOSAIC;
            o_ovf  <= 1'b0;
        end else begin
            fval_q <= i_fval;
            lval_q <= i_lval;
            if (frame_start) begin
                pat   <= pattern_e'(i_pattern);
                mode  <= mode_e'(i_mode);
                armed <= 1'b1;
            end
            y <= frame_start ? '0 : (line_end && y != X_SAT) ? y + 1'b1 : y;
            if (accept)
                x <= (x_cur == X_SAT) ? x_cur : x_cur + 1'b1;
            else if (line_start)
                x <= '0;
            o_ovf <= frame_start ? 1'b0 : o_ovf | (accept & ~in_range);
        end
    line_buf_1p #(.DATA_W(DATA_W), .DEPTH(LINE_MAX)) u_buf (
        .clk  (CLK),
        .en   (wr),
        .addr (x_cur[A_W-1:0]),
        .wdata(i_data),
        .rdata(ram_q)
    );
    // Delay registers shift only on accepted pixels so i_valid gaps do not skew the window
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_cur   <= '0;
            cur_d    <= '0;
            prev_d   <= '0;
        end else begin
            s1_valid <= wr;
            if (wr) begin
                prev_d <= ram_q;
                cur_d  <= s1_cur;
                s1_cur <= i_data;
                s1_x   <= x_cur;
                s1_y   <= y_cur;
            end
        end
    always_comb begin
        win[0] = prev_d;
        win[1] = ram_q;
        win[2] = cur_d;
        win[3] = s1_cur;
        cx     = ~s1_x[0] ^ (pat == PAT_GRBG || pat == PAT_BGGR);
        cy     = ~s1_y[0] ^ (pat == PAT_GBRG || pat == PAT_BGGR);
        r_raw  = win[win_pos(cx, cy)];
        b_raw  = win[win_pos(~cx, ~cy)];
        g_sum  = {1'b0, win[win_pos(~cx, cy)]} + {1'b0, win[win_pos(cx, ~cy)]};
        emit   = s1_valid & armed &
                 ((mode == MODE_BIN) ? (s1_x[0] & s1_y[0]) : (s1_x != '0 && s1_y != '0));
    end
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_sol    <= 1'b0;
            o_r      <= '0;
            o_g      <= '0;
            o_b      <= '0;
            sof_pend <= 1'b0;
            last_y   <= '0;
        end else begin
            o_valid <= emit;
            o_sof   <= emit & sof_pend;
            o_sol   <= emit & (sof_pend | (s1_y != last_y));
            if (frame_start)
                sof_pend <= 1'b1;
            else if (emit)
                sof_pend <= 1'b0;
            if (emit) begin
                o_r    <= OUT_W'(r_raw >> (DATA_W - OUT_W));
                o_g    <= OUT_W'(g_sum >> (DATA_W + 1 - OUT_W));
                o_b    <= OUT_W'(b_raw >> (DATA_W - OUT_W));
                last_y <= s1_y;
            end
        end
endmodule

// File: tb/tb_bayer_demosaic_2x2.sv
// tb_bayer_demosaic_2x2: randomized frames checked against a raster-order reference model
module tb_bayer_demosaic_2x2;
    localparam int DW = 10, OW = 8, LM = 1024, XW = 11, MAXW = LM + 3;
    logic CLK = 0, RST_N = 0, i_fval = 0, i_lval = 0, i_valid = 0, i_mode = 0;
    logic [DW-1:0] i_data = 0;
    logic [1:0] i_pattern = 0;
    logic [OW-1:0] o_r, o_g, o_b;
    logic o_valid, o_sof, o_sol, o_ovf;
    int passed = 0, total = 0, cyc = 0;
    typedef struct packed {
        logic [OW-1:0] r, g, b;
        logic sof, sol;
        logic [31:0] t;
    } ev_t;
    ev_t obs_q[$], exp_q[$], ref_q[$];
    logic [DW-1:0] pix [16][MAXW];
    int acc [16][MAXW];

    bayer_demosaic_2x2 #(.DATA_W(DW), .OUT_W(OW), .LINE_MAX(LM), .X_W(XW)) dut (
        .CLK(CLK), .RST_N(RST_N), .i_fval(i_fval), .i_lval(i_lval), .i_valid(i_valid),
        .i_data(i_data), .i_pattern(i_pattern), .i_mode(i_mode),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_valid(o_valid), .o_sof(o_sof), .o_sol(o_sol), .o_ovf(o_ovf)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (o_valid) obs_q.push_back({o_r, o_g, o_b, o_sof, o_sol, 32'(cyc)});

    function automatic string fmt(ev_t e);
        return $sformatf("r=%0d g=%0d b=%0d sof=%b sol=%b t=%0d", e.r, e.g, e.b, e.sof, e.sol, e.t);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_random(int w, int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) pix[y][x] = DW'($urandom_range(1023));
    endtask

    task automatic fill_flat(int w, int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                pix[y][x] = (x % 2 == 0 && y % 2 == 0) ? DW'(400) : (x % 2 == 1 && y % 2 == 1) ? DW'(100) : DW'(200);
    endtask

    task automatic frame_begin(int pat, int mode, bit sim);
        i_pattern = 2'(pat);
        i_mode = 1'(mode);
        i_fval = 1;
        if (!sim) begin
            tick();
            tick();
        end
    endtask

    task automatic drive_pixel(int y, int x, int gap);
        while (int'($urandom_range(99)) < gap) begin
            i_valid = 0;
            i_data = DW'($urandom_range(1023));
            tick();
        end
        i_valid = 1;
        i_data = pix[y][x];
        acc[y][x] = cyc;
        tick();
    endtask

    task automatic row_end(int y, bit last);
        i_valid = 0;
        i_lval = 0;
        if (last) i_fval = 0;
        tick();
        tick();
        if (y == 0) begin
            i_pattern = 2'($urandom_range(3));
            i_mode = 1'($urandom_range(1));
        end
    endtask

    task automatic drive_row(int y, int w, int gap, bit last);
        i_lval = 1;
        for (int x = 0; x < w; x++) drive_pixel(y, x, gap);
        row_end(y, last);
    endtask

    task automatic drive_frame(int w, int h, int pat, int mode, int gap, bit sim);
        obs_q.delete();
        frame_begin(pat, mode, sim);
        for (int y = 0; y < h; y++) drive_row(y, w, gap, y == h - 1);
        tick();
        tick();
    endtask

    // Reference: absolute pixel coordinates and the Bayer tile decide each sample's colour
    function automatic void build_exp(int w, int h, int pat, int mode);
        int we;
        bit first;
        we = w < LM ? w : LM;
        first = 1;
        exp_q.delete();
        for (int y = 1; y < h; y++) begin
            bit row_first;
            row_first = 1;
            for (int x = 1; x < we; x++) begin
                int rs, gs, bs;
                if (mode == 1 && !(x % 2 == 1 && y % 2 == 1)) continue;
                rs = 0; gs = 0; bs = 0;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        int col, row, c, r;
                        col = x - 1 + dx;
                        row = y - 1 + dy;
                        c = (col % 2) ^ (pat % 2);
                        r = (row % 2) ^ (pat / 2);
                        if (c == 0 && r == 0) rs = int'(pix[row][col]);
                        else if (c == 1 && r == 1) bs = int'(pix[row][col]);
                        else gs += int'(pix[row][col]);
                    end
                exp_q.push_back({OW'(rs >> (DW - OW)), OW'((gs / 2) >> (DW - OW)), OW'(bs >> (DW - OW)),
                                 first, row_first, 32'(acc[y][x] + 2)});
                first = 0;
                row_first = 0;
            end
        end
    endfunction

    task automatic test_reset();
        repeat (3) tick();
        total++;
        if ({o_valid, o_sof, o_sol, o_ovf} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {o_valid, o_sof, o_sol, o_ovf});
        else passed++;
        total++;
        if ({o_r, o_g, o_b} !== '0) $display("FAIL reset_rgb: got %0d/%0d/%0d expected 0/0/0", o_r, o_g, o_b);
        else passed++;
        RST_N = 1;
        repeat (3) tick();
        total++;
        if (o_valid !== 1'b0) $display("FAIL idle_valid: got %b expected 0", o_valid);
        else passed++;
    endtask

    task automatic test_flat(int pat, int er, int eb);
        fill_flat(4, 4);
        drive_frame(4, 4, pat, 0, 0, 0);
        build_exp(4, 4, pat, 0);
        total++;
        if (obs_q.size() != 9) $display("FAIL flat%0d_count: got %0d expected 9", pat, obs_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = i < obs_q.size() ? obs_q[i] : '1;
            total++;
            if (o !== exp_q[i]) $display("FAIL flat%0d_px%0d: got %s expected %s", pat, i, fmt(o), fmt(exp_q[i]));
            else passed++;
            total++;
            if ({o.r, o.g, o.b} !== {OW'(er), OW'(50), OW'(eb)})
                $display("FAIL flat%0d_const%0d: got %0d/%0d/%0d expected %0d/50/%0d", pat, i, o.r, o.g, o.b, er, eb);
            else passed++;
        end
    endtask

    task automatic test_bin_ramp();
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 8; x++) pix[y][x] = DW'(((y * 8 + x) * 37) % 1024);
        drive_frame(8, 6, 0, 1, 0, 1);
        build_exp(8, 6, 0, 1);
        total++;
        if (obs_q.size() != 12) $display("FAIL bin_count: got %0d expected 12", obs_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = i < obs_q.size() ? obs_q[i] : '1;
            total++;
            if (o !== exp_q[i]) $display("FAIL bin_px%0d: got %s expected %s", i, fmt(o), fmt(exp_q[i]));
            else passed++;
        end
    endtask

    task automatic test_overflow();
        int pat;
        pat = int'($urandom_range(3));
        fill_random(MAXW, 3);
        obs_q.delete();
        frame_begin(pat, 0, 0);
        total++;
        if (o_ovf !== 1'b0) $display("FAIL ovf_start: got %b expected 0", o_ovf);
        else passed++;
        for (int y = 0; y < 3; y++) drive_row(y, MAXW, 0, y == 2);
        repeat (5) tick();
        total++;
        if (o_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", o_ovf);
        else passed++;
        build_exp(MAXW, 3, pat, 0);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = i < obs_q.size() ? obs_q[i] : '1;
            total++;
            if (o !== exp_q[i]) $display("FAIL ovf_px%0d: got %s expected %s", i, fmt(o), fmt(exp_q[i]));
            else passed++;
        end
        fill_random(4, 4);
        frame_begin(pat, 0, 0);
        total++;
        if (o_ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", o_ovf);
        else passed++;
        for (int y = 0; y < 4; y++) drive_row(y, 4, 0, y == 3);
    endtask

    task automatic test_reset_mid();
        int pat;
        pat = int'($urandom_range(3));
        fill_random(8, 8);
        obs_q.delete();
        frame_begin(pat, 0, 0);
        for (int y = 0; y < 3; y++) drive_row(y, 8, 0, 0);
        i_lval = 1;
        for (int x = 0; x < 4; x++) drive_pixel(3, x, 0);
        total++;
        if (obs_q.size() == 0) $display("FAIL pre_reset_out: got 0 outputs expected some");
        else passed++;
        RST_N = 0;
        #1;
        total++;
        if ({o_valid, o_r, o_g, o_b} !== '0) $display("FAIL async_reset: got v=%b %0d/%0d/%0d expected all 0", o_valid, o_r, o_g, o_b);
        else passed++;
        tick();
        RST_N = 1;
        obs_q.delete();
        for (int x = 4; x < 8; x++) drive_pixel(3, x, 0);
        row_end(3, 0);
        for (int y = 4; y < 8; y++) drive_row(y, 8, 0, y == 7);
        tick();
        total++;
        if (obs_q.size() != 0) $display("FAIL unarmed_out: got %0d outputs expected 0", obs_q.size());
        else passed++;
        fill_random(8, 8);
        drive_frame(8, 8, pat, 0, 0, 0);
        build_exp(8, 8, pat, 0);
        total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL rearm_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = i < obs_q.size() ? obs_q[i] : '1;
            total++;
            if (o !== exp_q[i]) $display("FAIL rearm_px%0d: got %s expected %s", i, fmt(o), fmt(exp_q[i]));
            else passed++;
        end
    endtask

    task automatic test_gaps();
        int pat;
        pat = int'($urandom_range(3));
        fill_random(16, 16);
        drive_frame(16, 16, pat, 0, 0, 0);
        ref_q = obs_q;
        drive_frame(16, 16, pat, 0, 50, 0);
        build_exp(16, 16, pat, 0);
        total++;
        if (obs_q.size() != 225 || ref_q.size() != 225)
            $display("FAIL gap_count: got %0d/%0d expected 225/225", obs_q.size(), ref_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            ev_t o, q;
            o = i < obs_q.size() ? obs_q[i] : '1;
            q = i < ref_q.size() ? ref_q[i] : '1;
            total++;
            if (o !== exp_q[i] || o[OW*3+1:32] !== q[OW*3+1:32])
                $display("FAIL gap_px%0d: got %s nogap %s expected %s", i, fmt(o), fmt(q), fmt(exp_q[i]));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            int w, h, pat, mode;
            w = int'($urandom_range(12, 4));
            h = int'($urandom_range(8, 3));
            pat = int'($urandom_range(3));
            mode = int'($urandom_range(1));
            fill_random(w, h);
            drive_frame(w, h, pat, mode, 25, 1'($urandom_range(1)));
            build_exp(w, h, pat, mode);
            total++;
            if (obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_count: got %0d expected %0d", n, obs_q.size(), exp_q.size());
            else passed++;
            foreach (exp_q[i]) begin
                ev_t o;
                o = i < obs_q.size() ? obs_q[i] : '1;
                total++;
                if (o !== exp_q[i]) $display("FAIL rnd%0d_px%0d: got %s expected %s", n, i, fmt(o), fmt(exp_q[i]));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat(0, 100, 25);
        test_flat(3, 25, 100);
        test_bin_ramp();
        test_overflow();
        test_reset_mid();
        test_gaps();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bayer_demosaic_2x2.md
# bayer_demosaic_2x2

Parametrised Bayer-to-RGB converter for the D8M camera path, operating on a single pixel clock. It keeps one internal line buffer and forms each output pixel from a 2x2 raw window. It supports four selectable Bayer phases and two modes: full-rate demosaic, or 2x2 binning at half resolution. It sits between the raw sensor stream (frame/line valid plus data) and the RGB frame-buffer or VGA path, and replaces the fixed-phase, fixed-width converter with its external line buffer.

## Interface
- DATA_W, 10: raw pixel width.
- OUT_W, 8: per-channel output width (OUT_W <= DATA_W).
- LINE_MAX, 1024: maximum pixels per line; this is the line buffer depth.
- X_W, 11: column/row counter width (2^X_W > LINE_MAX).
- CLK  in  1  pixel clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- i_fval  in  1  frame valid.
- i_lval  in  1  line valid.
- i_valid  in  1  pixel qualifier; data is accepted only when i_fval & i_lval & i_valid.
- i_data  in  DATA_W  raw Bayer sample.
- i_pattern  in  2  0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR. Sampled at frame start.
- i_mode  in  1  0=demosaic full rate, 1=2x2 bin. Sampled at frame start.
- o_r, o_g, o_b  out  OUT_W  RGB output.
- o_valid  out  1  output pixel strobe.
- o_sof  out  1  with o_valid, first output pixel of a frame.
- o_sol  out  1  with o_valid, first output pixel of each output line.
- o_ovf  out  1  sticky: the current frame had a line longer than LINE_MAX.

## Operation
- Frame start is the rising edge of i_fval, detected against a registered copy.
  - On frame start: y := 0, pattern/mode latched, o_ovf cleared, armed := 1.
- Line start is the rising edge of i_lval: x := 0. Line end is the falling edge of i_lval: y := y+1, saturating at 2^X_W-1.
- Each accepted pixel increments x.
  - If x >= LINE_MAX, the pixel is dropped: no buffer write, no output, o_ovf := 1.
- Line buffer behaviour:
  - Each accepted pixel with x < LINE_MAX reads address x (previous row), then writes i_data at address x.
  - Read-during-write to the same address returns old data.
- Window for accepted pixel (x,y): P00=prev[x-1], P01=prev[x], P10=cur[x-1], P11=cur[x]. Column x-1 values come from one-deep delay registers.
- Colour phase:
  - cx = (x-1)[0]^pat[0] and cy = (y-1)[0]^pat[1], both taken at P00.
  - R is the window position at parity (cx,cy)=(0,0) relative to P00; B is the position at (1,1); the remaining two positions are G.
  - G = (Ga+Gb)>>1, computed in a DATA_W+1 bit sum.
  - Outputs take the top OUT_W bits of R, G and B (truncation, no rounding).
- Output rule, mode 0: an output is produced for each accepted pixel with x>=1 and y>=1, giving (W-1)x(H-1) pixels.
- Output rule, mode 1: an output is produced only when x and y are both odd, giving floor(W/2)xfloor(H/2) pixels.
- Gating:
  - Outputs require armed=1. After reset, armed=0 until the next frame start, so a partial frame is never emitted.
  - i_fval falling does not clear armed.
- o_sof marks the first output after frame start; o_sol marks the first output of each line that produces any output.

## Timing
- Reset value: all outputs 0; armed=0; x, y and delay registers 0. Line buffer contents are not reset.
- Latency: fixed 2 CLK from the accepted pixel to o_valid.
  - Stage 1: buffer read plus capture of the current pixel and x/y.
  - Stage 2: window select, add and truncate into output registers.
- o_r/o_g/o_b hold their last value when o_valid=0.
- Throughput: 1 pixel/CLK sustained. Gaps in i_valid inside a line are allowed and stall nothing; x advances only on accepted pixels.
- Simultaneous events:
  - i_lval falling and i_fval falling in the same cycle: y increments, then frame ends.
  - i_fval rising and i_lval rising in the same cycle: x=0 and y=0.
- i_pattern/i_mode changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame: outputs go to 0 immediately; the in-flight pipeline is discarded.

## Structure
- Package demosaic_pkg:
  - pattern enum (RGGB/GRBG/GBRG/BGGR).
  - mode enum.
  - parity-to-position helper function.
- Sub-module line_buf_1p: parametrised DATA_W x LINE_MAX synchronous RAM with read-old-data semantics, inferable as block RAM.

## Test plan
- RGGB, mode 0, 4x4 frame with R=400, G=200, B=100 everywhere -> 9 outputs, each R=100, G=50, B=25; o_sof on the first; o_sol on outputs 1, 4 and 7.
- Same frame with i_pattern=3 (BGGR) -> R=25, B=100, G=50, checking phase swap.
- Mode 1, 8x6 RGGB ramp -> exactly 12 outputs, each 2 CLK after the odd/odd pixel, with G = (Gr+Gb)>>1 truncated.
- Line of LINE_MAX+3 pixels -> o_ovf=1 until the next frame start; no output for columns >= LINE_MAX; the next row is still correct.
- RST_N pulsed mid-frame -> outputs 0 immediately; no o_valid until after the next i_fval rise; the next frame is bit-exact to the golden model.
- Random i_valid gaps (50%) in a 16x16 frame -> output sequence identical to the gap-free run.
